// File: rtl/input_conditioner.sv
// input_conditioner: per-bit sync, polarity normalise, debounce FSM, press/release/auto-repeat pulses.
module input_conditioner #(
  parameter int                  N_INPUTS        = 8,
  parameter int                  DEBOUNCE_CYCLES = 500000,
  parameter int                  HOLD_CYCLES     = 25000000,
  parameter int                  REPEAT_CYCLES   = 5000000,
  parameter logic [N_INPUTS-1:0] ACTIVE_LOW      = '1,
  parameter logic [N_INPUTS-1:0] REPEAT_EN       = '0
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] level_out,
  output logic [N_INPUTS-1:0] press_pulse,
  output logic [N_INPUTS-1:0] release_pulse,
  output logic [N_INPUTS-1:0] repeat_pulse,
  output logic                any_event
);
  localparam int MAX_DH = DEBOUNCE_CYCLES > HOLD_CYCLES ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = MAX_DH > REPEAT_CYCLES ? MAX_DH : REPEAT_CYCLES;
  localparam int W      = $clog2(MAX_C + 1);
  localparam logic [W-1:0] D_END = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] H_END = W'(HOLD_CYCLES - 1);
  localparam logic [W-1:0] R_END = W'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return v + W'(v != '1);
  endfunction
  logic [N_INPUTS-1:0] s1, s2, p;
  // p is registered so every path from pin to output has the same fixed latency
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
      p  <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      p  <= s2 ^ ACTIVE_LOW;
    end
  end
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
    state_t         st;
    logic [W-1:0]   cnt, hold;
    logic           rep, lvl, prs, rls, rpt;
    always_ff @(posedge clk_clk) begin
      prs <= 1'b0;
      rls <= 1'b0;
      rpt <= 1'b0;
      if (reset_reset) begin
        st   <= RELEASED;
        cnt  <= '0;
        hold <= '0;
        rep  <= 1'b0;
        lvl  <= 1'b0;
      end else begin
        case (st)
          RELEASED: if (p[i]) begin
            st  <= PRESS_PEND;
            cnt <= W'(1);
          end
          PRESS_PEND: if (!p[i]) begin
            st  <= RELEASED;
            cnt <= '0;
          end else if (cnt == D_END) begin
            st   <= PRESSED;
            lvl  <= 1'b1;
            prs  <= 1'b1;
            hold <= '0;
            rep  <= 1'b0;
          end else cnt <= sat_inc(cnt);
          PRESSED: if (!p[i]) begin
            st  <= RELEASE_PEND;
            cnt <= W'(1);
          end else if (REPEAT_EN[i]) begin
            if (hold == (rep ? R_END : H_END)) begin
              rpt  <= 1'b1;
              hold <= '0;
              rep  <= 1'b1;
            end else hold <= sat_inc(hold);
          end
          RELEASE_PEND: if (p[i]) begin
            st  <= PRESSED;
            cnt <= '0;
          end else if (cnt == D_END) begin
            st   <= RELEASED;
            lvl  <= 1'b0;
            rls  <= 1'b1;
            hold <= '0;
            rep  <= 1'b0;
          end else cnt <= sat_inc(cnt);
          default: st <= RELEASED;
        endcase
      end
    end
    assign level_out[i]     = lvl;
    assign press_pulse[i]   = prs;
    assign release_pulse[i] = rls;
    assign repeat_pulse[i]  = rpt;
  end
  assign any_event = |(press_pulse | release_pulse | repeat_pulse);
endmodule
